// File: rtl/router_output_allocator.sv
// Per-output switch allocator: round-robin packet-granular arbitration with downstream credit tracking.
// Build option ROUTER_OUTPUT_ALLOC_STATS_EN adds saturating flit/stall statistics counters.
module router_output_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int STAT_WIDTH        = 16,
  localparam int IDX_W            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                    clk_noc,
  input  logic                    rst_n,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    locked,
  output logic                    credit_err
`ifdef ROUTER_OUTPUT_ALLOC_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   flit_count,
  output logic [STAT_WIDTH-1:0]   stall_count
`endif
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_INPUTS - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        owner_reg, owner_next;
  logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
  logic                    credit_err_reg, credit_err_next;

  logic [NUM_INPUTS-1:0]   elig;
  logic                    rr_found;
  logic [IDX_W-1:0]        rr_pick;
  logic                    has_credit;
  logic                    send;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_tail;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  assign elig       = req & ~turn_disable;
  assign has_credit = (credits_reg != '0);
  assign sel_tail   = req_is_tail[sel_idx];

  // Circular search for the first eligible input at or after rr_ptr.
  always_comb begin
    logic [IDX_W-1:0] cand;
    rr_found = 1'b0;
    rr_pick  = rr_ptr_reg;
    cand     = rr_ptr_reg;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (send && !sel_tail) state_next = LOCKED;
      LOCKED:  if (send && sel_tail)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant is combinational so the flit crosses the link in the cycle it is granted.
  always_comb begin
    send    = 1'b0;
    sel_idx = rr_pick;
    case (state_reg)
      IDLE: begin
        sel_idx = rr_pick;
        send    = rr_found && has_credit;
      end
      LOCKED: begin
        sel_idx = owner_reg;
        send    = req[owner_reg] && has_credit;
      end
      default: begin
        sel_idx = rr_pick;
        send    = 1'b0;
      end
    endcase
    if (!rst_n) begin
      send = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_grant
    assign grant[gi] = send && (sel_idx == IDX_W'(gi));
  end

  assign send_out   = send;
  assign grant_idx  = sel_idx;
  assign locked     = (state_reg == LOCKED);
  assign credits    = credits_reg;
  assign credit_err = credit_err_reg;

  // Pointer moves past the winner on every packet start (IDLE) and on every tail.
  always_comb begin
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    if (send && (state_reg == IDLE) && !sel_tail) begin
      owner_next = sel_idx;
    end
    if (send && ((state_reg == IDLE) || sel_tail)) begin
      rr_ptr_next = next_idx(sel_idx);
    end
  end

  always_comb begin
    credits_next    = credits_reg;
    credit_err_next = credit_err_reg;
    if (credit_in && (credits_reg == CREDIT_MAX)) begin
      credit_err_next = 1'b1;
    end
    case ({send, credit_in})
      2'b10:   credits_next = credits_reg - CREDIT_ONE;
      2'b01:   if (credits_reg != CREDIT_MAX) credits_next = credits_reg + CREDIT_ONE;
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= '0;
      rr_ptr_reg     <= '0;
      credits_reg    <= CREDIT_MAX;
      credit_err_reg <= 1'b0;
    end else begin
      owner_reg      <= owner_next;
      rr_ptr_reg     <= rr_ptr_next;
      credits_reg    <= credits_next;
      credit_err_reg <= credit_err_next;
    end
  end

`ifdef ROUTER_OUTPUT_ALLOC_STATS_EN
  logic [STAT_WIDTH-1:0] flit_count_reg;
  logic [STAT_WIDTH-1:0] stall_count_reg;
  logic                  stall_cond;

  // A stall is a cycle where an allocatable request is blocked only by lack of credit.
  assign stall_cond = !has_credit &&
                      ((state_reg == IDLE) ? (|elig) : req[owner_reg]);

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      flit_count_reg  <= '0;
      stall_count_reg <= '0;
    end else begin
      if (send && (flit_count_reg != '1)) begin
        flit_count_reg <= flit_count_reg + STAT_WIDTH'(1);
      end
      if (stall_cond && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + STAT_WIDTH'(1);
      end
    end
  end

  assign flit_count  = flit_count_reg;
  assign stall_count = stall_count_reg;
`else
  // Statistics omitted; allocation logic above is identical either way.
`endif

endmodule
